div_seq_ctrl: RTL and testbench

//  Sequencer for the multi-cycle DIV/DIVU path in EXE. Takes the is_div / is_sign_div decode bits and operands

---
 rtl/div_seq_ctrl.sv | 131 +++++++++++++
 tb/tb_div_seq_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/div_seq_ctrl.sv
// Multi-cycle DIV/DIVU sequencer: radix-2 restoring division over DATA_W cycles,
// stalling ID/EXE until quotient/remainder are ready for the HI/LO write path.
module div_seq_ctrl #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              is_div,
    input  logic              is_sign_div,
    input  logic              flush,
    input  logic              hold,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic              div_stall,
    output logic              res_valid,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder,
    output logic              busy
);

    localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rem_q, rem_d;
    logic [DATA_W-1:0] quo_q, quo_d;
    logic [DATA_W-1:0] dvs_q, dvs_d;
    logic              q_neg_q, q_neg_d;
    logic              r_neg_q, r_neg_d;

    logic [DATA_W-1:0] dvd_mag, dvs_mag;
    logic [DATA_W:0]   rem_sh, trial;
    logic              q_bit;
    logic [DATA_W-1:0] rem_step, quo_step;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
        end
    end

    // Operand magnitudes and one restoring step on the {rem, quo} pair.
    always_comb begin
        dvd_mag  = (is_sign_div && dividend[DATA_W-1]) ? -dividend : dividend;
        dvs_mag  = (is_sign_div && divisor[DATA_W-1])  ? -divisor  : divisor;
        rem_sh   = {rem_q, quo_q[DATA_W-1]};
        trial    = rem_sh - {1'b0, dvs_q};
        q_bit    = ~trial[DATA_W];
        rem_step = q_bit ? trial[DATA_W-1:0] : rem_sh[DATA_W-1:0];
        quo_step = {quo_q[DATA_W-2:0], q_bit};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        case (state_q)
            IDLE: begin
                if (is_div && !flush) begin
                    if (divisor == '0) begin
                        state_d = DONE;
                        quo_d   = '0;
                        rem_d   = dividend;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = '0;
                        quo_d   = dvd_mag;
                        rem_d   = '0;
                        dvs_d   = dvs_mag;
                        q_neg_d = is_sign_div && (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
                        r_neg_d = is_sign_div && dividend[DATA_W-1];
                    end
                end
            end
            BUSY: begin
                rem_d = rem_step;
                quo_d = quo_step;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    if (q_neg_q) quo_d = -quo_step;
                    if (r_neg_q) rem_d = -rem_step;
                end
            end
            DONE: begin
                if (!hold) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Flush wins over every state; datapath registers are left stale.
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    always_comb begin
        div_stall = is_div && !flush && (state_q != DONE);
        res_valid = (state_q == DONE);
        busy      = (state_q == BUSY);
        quotient  = quo_q;
        remainder = rem_q;
    end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed self-checking bench for div_seq_ctrl (DATA_W = 32).
module tb_div_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        is_div;
    logic        is_sign_div;
    logic        flush;
    logic        hold;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        div_stall;
    logic        res_valid;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        busy;

    int checks = 0;
    int errors = 0;

    div_seq_ctrl #(.DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .is_div     (is_div),
        .is_sign_div(is_sign_div),
        .flush      (flush),
        .hold       (hold),
        .dividend   (dividend),
        .divisor    (divisor),
        .div_stall  (div_stall),
        .res_valid  (res_valid),
        .quotient   (quotient),
        .remainder  (remainder),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Presents a division in the next cycle and runs to its DONE cycle, leaving is_div high.
    task automatic do_div(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eq, input logic [31:0] er, input int exp_stall);
        int n;
        n = 0;
        @(negedge clk);
        is_div = 1'b1; is_sign_div = sgn; dividend = a; divisor = b;
        #1;
        while (div_stall && n < 100) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                dividend = ~a;
                divisor  = 32'h5;
            end
            #1;
            if (n == 1) chk({tag, "_busy"}, {31'b0, busy}, {31'b0, b != 32'h0});
        end
        chk({tag, "_stall_cycles"}, n, exp_stall);
        chk({tag, "_valid"}, {31'b0, res_valid}, 32'h1);
        chk({tag, "_quo"}, quotient, eq);
        chk({tag, "_rem"}, remainder, er);
    endtask

    task automatic drop_and_check_idle(input string tag);
        @(negedge clk);
        is_div = 1'b0;
        #1;
        chk({tag, "_idle_valid"}, {31'b0, res_valid}, 32'h0);
    endtask

    initial begin
        int seen;
        rst = 1'b1; is_div = 1'b0; is_sign_div = 1'b0; flush = 1'b0; hold = 1'b0;
        dividend = '0; divisor = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_valid", {31'b0, res_valid}, 32'h0);
        chk("rst_busy",  {31'b0, busy}, 32'h0);
        chk("rst_stall", {31'b0, div_stall}, 32'h0);
        chk("rst_quo",   quotient, 32'h0);
        chk("rst_rem",   remainder, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        do_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33);
        drop_and_check_idle("divu_100_7");

        do_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
        drop_and_check_idle("div_m7_2");
        do_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 33);
        drop_and_check_idle("div_7_m2");

        do_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 33);
        drop_and_check_idle("div_ovf");
        do_div("divu_5_0", 1'b0, 32'd5, 32'd0, 32'd0, 32'd5, 1);
        drop_and_check_idle("divu_5_0");
        do_div("div_m7_0", 1'b1, 32'hFFFF_FFF9, 32'd0, 32'd0, 32'hFFFF_FFF9, 1);
        drop_and_check_idle("div_m7_0");

        // Flush in BUSY cycle 10.
        @(negedge clk);
        is_div = 1'b1; is_sign_div = 1'b0; dividend = 32'd1000; divisor = 32'd3;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        #1;
        chk("flush_busy_before", {31'b0, busy}, 32'h1);
        chk("flush_stall", {31'b0, div_stall}, 32'h0);
        @(negedge clk);
        flush = 1'b0; is_div = 1'b0;
        #1;
        chk("flush_busy_after", {31'b0, busy}, 32'h0);
        seen = 0;
        repeat (40) begin
            @(negedge clk); #1;
            if (res_valid) seen++;
        end
        chk("flush_no_valid", seen, 0);
        do_div("divu_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33);
        drop_and_check_idle("divu_9_3");

        // Hold for 4 cycles on reaching DONE.
        hold = 1'b1;
        do_div("hold", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33);
        repeat (3) begin
            @(negedge clk); #1;
            chk("hold_valid", {31'b0, res_valid}, 32'h1);
            chk("hold_stall", {31'b0, div_stall}, 32'h0);
            chk("hold_busy",  {31'b0, busy}, 32'h0);
            chk("hold_quo",   quotient, 32'd14);
            chk("hold_rem",   remainder, 32'd2);
        end
        @(negedge clk);
        hold = 1'b0;
        #1;
        chk("hold_drop_valid", {31'b0, res_valid}, 32'h1);
        drop_and_check_idle("hold");

        // Back-to-back DIVUs.
        do_div("b2b_1", 1'b0, 32'd20, 32'd6, 32'd3, 32'd2, 33);
        do_div("b2b_2", 1'b0, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 32'd15, 33);
        drop_and_check_idle("b2b");

        // Reset mid-BUSY.
        @(negedge clk);
        is_div = 1'b1; is_sign_div = 1'b0; dividend = 32'd77; divisor = 32'd5;
        repeat (5) @(negedge clk);
        #1;
        chk("mid_rst_busy_before", {31'b0, busy}, 32'h1);
        @(negedge clk);
        rst = 1'b1; is_div = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_busy",  {31'b0, busy}, 32'h0);
        chk("mid_rst_valid", {31'b0, res_valid}, 32'h0);
        chk("mid_rst_stall", {31'b0, div_stall}, 32'h0);
        chk("mid_rst_quo",   quotient, 32'h0);
        chk("mid_rst_rem",   remainder, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
